// File: rtl/branch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : branch_redirect_ctrl_if
// Brief     : EX-stage control-flow resolution bundle. Carries the EX-stage
//             branch operands, the redirect handshake to fetch, pipeline
//             flush/stall controls, predictor-update and trap pulses.
//             The slave modport is the resolution controller; the master
//             modport is the surrounding pipeline (EX operands + fetch).
// Options   : BRANCH_REDIRECT_PERF_EN adds the three performance counters.
// Revision  : 1.0 - initial release
// ============================================================================
interface branch_redirect_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
);
    // EX-stage operands
    logic              ExValid;
    logic [4:0]        ExBrOp;
    logic              ExIsJalr;
    logic              ExTaken;
    logic [XLEN-1:0]   ExPC;
    logic [XLEN-1:0]   ExImm;
    logic [XLEN-1:0]   ExRs1;
    logic              ExPredTaken;
    logic [XLEN-1:0]   ExPredTarget;
    // Redirect handshake and pipeline control
    logic              RedirectReady;
    logic              RedirectValid;
    logic [XLEN-1:0]   RedirectPC;
    logic              FlushIF;
    logic              FlushID;
    logic              StallEX;
    // Predictor update
    logic              UpdValid;
    logic [XLEN-1:0]   UpdPC;
    logic              UpdTaken;
    logic [XLEN-1:0]   UpdTarget;
    // Misaligned-target trap
    logic              TrapValid;
    logic [XLEN-1:0]   TrapPC;
    logic [XLEN-1:0]   TrapTval;
`ifdef BRANCH_REDIRECT_PERF_EN
    logic [PERF_W-1:0] PerfBranches;
    logic [PERF_W-1:0] PerfMispred;
    logic [PERF_W-1:0] PerfStallCyc;
`endif

    modport slave (
`ifdef BRANCH_REDIRECT_PERF_EN
        output PerfBranches, output PerfMispred, output PerfStallCyc,
`endif
        input  ExValid, input ExBrOp, input ExIsJalr, input ExTaken,
        input  ExPC, input ExImm, input ExRs1, input ExPredTaken,
        input  ExPredTarget, input RedirectReady,
        output RedirectValid, output RedirectPC, output FlushIF,
        output FlushID, output StallEX, output UpdValid, output UpdPC,
        output UpdTaken, output UpdTarget, output TrapValid, output TrapPC,
        output TrapTval
    );

    modport master (
`ifdef BRANCH_REDIRECT_PERF_EN
        input  PerfBranches, input PerfMispred, input PerfStallCyc,
`endif
        output ExValid, output ExBrOp, output ExIsJalr, output ExTaken,
        output ExPC, output ExImm, output ExRs1, output ExPredTaken,
        output ExPredTarget, output RedirectReady,
        input  RedirectValid, input RedirectPC, input FlushIF,
        input  FlushID, input StallEX, input UpdValid, input UpdPC,
        input  UpdTaken, input UpdTarget, input TrapValid, input TrapPC,
        input  TrapTval
    );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : RV32I EX-stage control-flow resolution. Computes the real branch
//            target, compares it with the fetch prediction, and on mispredict
//            holds a redirect request (with IF/ID flush and EX stall) until
//            fetch accepts it. Emits predictor-update pulses for every
//            resolved control-flow instruction and a trap pulse for
//            misaligned taken targets. All outputs are registered.
// Options  : BRANCH_REDIRECT_PERF_EN adds PerfBranches, PerfMispred and
//            PerfStallCyc wrapping counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl #(
    parameter int XLEN   = 32,
    parameter int PERF_W = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    branch_redirect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] C_SEQ_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] C_LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    // ------------------------------------------------------------------
    // Resolution datapath (pure combinational, evaluated every cycle)
    // ------------------------------------------------------------------
    logic            w_is_cf;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_act_next;
    logic            w_misaligned;
    logic            w_mispredict;
    // funct3 only matters to the branch-evaluation unit, not here
    logic            w_unused_funct3;

    // ExBrOp[4]=1 implies [4:3]!=00, so the second term covers JAL/JALR too
    assign w_is_cf         = bus.ExValid && (bus.ExBrOp[4:3] != 2'b00);
    assign w_target        = bus.ExIsJalr ? ((bus.ExRs1 + bus.ExImm) & C_LSB_MASK)
                                          : (bus.ExPC + bus.ExImm);
    assign w_act_next      = bus.ExTaken ? w_target : (bus.ExPC + C_SEQ_STEP);
    assign w_misaligned    = bus.ExTaken && (w_target[1:0] != 2'b00);
    assign w_mispredict    = (bus.ExTaken != bus.ExPredTaken) ||
                             (bus.ExTaken && (w_target != bus.ExPredTarget));
    assign w_unused_funct3 = ^bus.ExBrOp[2:0];

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t          r_state_q,          w_state_d;
    logic            r_redirect_valid_q, w_redirect_valid_d;
    logic [XLEN-1:0] r_redirect_pc_q,    w_redirect_pc_d;
    logic            r_flush_if_q,       w_flush_if_d;
    logic            r_flush_id_q,       w_flush_id_d;
    logic            r_stall_ex_q,       w_stall_ex_d;
    logic            r_upd_valid_q,      w_upd_valid_d;
    logic [XLEN-1:0] r_upd_pc_q,         w_upd_pc_d;
    logic            r_upd_taken_q,      w_upd_taken_d;
    logic [XLEN-1:0] r_upd_target_q,     w_upd_target_d;
    logic            r_trap_valid_q,     w_trap_valid_d;
    logic [XLEN-1:0] r_trap_pc_q,        w_trap_pc_d;
    logic [XLEN-1:0] r_trap_tval_q,      w_trap_tval_d;

    // Next-state and next-output logic; payload buses hold when not updated
    always_comb begin
        w_state_d          = r_state_q;
        w_redirect_valid_d = r_redirect_valid_q;
        w_redirect_pc_d    = r_redirect_pc_q;
        w_flush_if_d       = r_flush_if_q;
        w_flush_id_d       = r_flush_id_q;
        w_stall_ex_d       = r_stall_ex_q;
        w_upd_valid_d      = 1'b0;
        w_upd_pc_d         = r_upd_pc_q;
        w_upd_taken_d      = r_upd_taken_q;
        w_upd_target_d     = r_upd_target_q;
        w_trap_valid_d     = 1'b0;
        w_trap_pc_d        = r_trap_pc_q;
        w_trap_tval_d      = r_trap_tval_q;

        case (r_state_q)
            ST_IDLE: begin
                w_redirect_valid_d = 1'b0;
                w_flush_if_d       = 1'b0;
                w_flush_id_d       = 1'b0;
                w_stall_ex_d       = 1'b0;
                if (w_is_cf) begin
                    // Predictor learns every resolved CF, trapping ones included
                    w_upd_valid_d  = 1'b1;
                    w_upd_pc_d     = bus.ExPC;
                    w_upd_taken_d  = bus.ExTaken;
                    w_upd_target_d = w_target;
                    if (w_misaligned) begin
                        // Trap wins over mispredict: the trap handler owns the PC
                        w_state_d      = ST_TRAP;
                        w_trap_valid_d = 1'b1;
                        w_trap_pc_d    = bus.ExPC;
                        w_trap_tval_d  = w_target;
                        w_flush_if_d   = 1'b1;
                        w_flush_id_d   = 1'b1;
                    end else if (w_mispredict) begin
                        w_state_d          = ST_REDIRECT;
                        w_redirect_valid_d = 1'b1;
                        w_redirect_pc_d    = w_act_next;
                        w_flush_if_d       = 1'b1;
                        w_flush_id_d       = 1'b1;
                        w_stall_ex_d       = 1'b1;
                    end
                end
            end
            ST_REDIRECT: begin
                // Request and pipeline controls hold until fetch takes it;
                // the EX inputs are deliberately ignored here
                if (r_redirect_valid_q && bus.RedirectReady) begin
                    w_state_d          = ST_IDLE;
                    w_redirect_valid_d = 1'b0;
                    w_flush_if_d       = 1'b0;
                    w_flush_id_d       = 1'b0;
                    w_stall_ex_d       = 1'b0;
                end
            end
            ST_TRAP: begin
                w_state_d    = ST_IDLE;
                w_flush_if_d = 1'b0;
                w_flush_id_d = 1'b0;
            end
            default: begin
                w_state_d          = ST_IDLE;
                w_redirect_valid_d = 1'b0;
                w_flush_if_d       = 1'b0;
                w_flush_id_d       = 1'b0;
                w_stall_ex_d       = 1'b0;
            end
        endcase
    end

    // State/output registers; async reset aborts any pending redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q          <= ST_IDLE;
            r_redirect_valid_q <= 1'b0;
            r_redirect_pc_q    <= '0;
            r_flush_if_q       <= 1'b0;
            r_flush_id_q       <= 1'b0;
            r_stall_ex_q       <= 1'b0;
            r_upd_valid_q      <= 1'b0;
            r_upd_pc_q         <= '0;
            r_upd_taken_q      <= 1'b0;
            r_upd_target_q     <= '0;
            r_trap_valid_q     <= 1'b0;
            r_trap_pc_q        <= '0;
            r_trap_tval_q      <= '0;
        end else begin
            r_state_q          <= w_state_d;
            r_redirect_valid_q <= w_redirect_valid_d;
            r_redirect_pc_q    <= w_redirect_pc_d;
            r_flush_if_q       <= w_flush_if_d;
            r_flush_id_q       <= w_flush_id_d;
            r_stall_ex_q       <= w_stall_ex_d;
            r_upd_valid_q      <= w_upd_valid_d;
            r_upd_pc_q         <= w_upd_pc_d;
            r_upd_taken_q      <= w_upd_taken_d;
            r_upd_target_q     <= w_upd_target_d;
            r_trap_valid_q     <= w_trap_valid_d;
            r_trap_pc_q        <= w_trap_pc_d;
            r_trap_tval_q      <= w_trap_tval_d;
        end
    end

    assign bus.RedirectValid = r_redirect_valid_q;
    assign bus.RedirectPC    = r_redirect_pc_q;
    assign bus.FlushIF       = r_flush_if_q;
    assign bus.FlushID       = r_flush_id_q;
    assign bus.StallEX       = r_stall_ex_q;
    assign bus.UpdValid      = r_upd_valid_q;
    assign bus.UpdPC         = r_upd_pc_q;
    assign bus.UpdTaken      = r_upd_taken_q;
    assign bus.UpdTarget     = r_upd_target_q;
    assign bus.TrapValid     = r_trap_valid_q;
    assign bus.TrapPC        = r_trap_pc_q;
    assign bus.TrapTval      = r_trap_tval_q;

`ifdef BRANCH_REDIRECT_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (free-running, wrap at 2^PERF_W)
    // ------------------------------------------------------------------
    logic [PERF_W-1:0] r_perf_branches_q, w_perf_branches_d;
    logic [PERF_W-1:0] r_perf_mispred_q,  w_perf_mispred_d;
    logic [PERF_W-1:0] r_perf_stall_q,    w_perf_stall_d;

    // Count resolved CFs, redirect entries and cycles spent redirecting
    always_comb begin
        w_perf_branches_d = r_perf_branches_q;
        w_perf_mispred_d  = r_perf_mispred_q;
        w_perf_stall_d    = r_perf_stall_q;
        if ((r_state_q == ST_IDLE) && w_is_cf) begin
            w_perf_branches_d = r_perf_branches_q + PERF_W'(1);
        end
        if ((r_state_q == ST_IDLE) && (w_state_d == ST_REDIRECT)) begin
            w_perf_mispred_d = r_perf_mispred_q + PERF_W'(1);
        end
        if (r_state_q == ST_REDIRECT) begin
            w_perf_stall_d = r_perf_stall_q + PERF_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_branches_q <= '0;
            r_perf_mispred_q  <= '0;
            r_perf_stall_q    <= '0;
        end else begin
            r_perf_branches_q <= w_perf_branches_d;
            r_perf_mispred_q  <= w_perf_mispred_d;
            r_perf_stall_q    <= w_perf_stall_d;
        end
    end

    assign bus.PerfBranches = r_perf_branches_q;
    assign bus.PerfMispred  = r_perf_mispred_q;
    assign bus.PerfStallCyc = r_perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences control-flow resolution in the EX stage of the RV32I pipeline.
- Takes the branch-taken decision from the branch-evaluation unit, computes the real target and compares it with the fetch-stage prediction.
- On mispredict: drives a redirect handshake to fetch, flushes IF/ID, stalls EX until fetch accepts.
- Also emits predictor-update pulses and misaligned-target traps.

Parameters:
- XLEN, 32, datapath/address width.
- PERF_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ExValid  in  1  EX holds a valid instruction this cycle.
- ExBrOp  in  5  branch opcode: [4]=1 JAL/JALR; [4:3]=00 not control-flow; otherwise conditional with funct3 in [2:0].
- ExIsJalr  in  1  EX instruction is JALR.
- ExTaken  in  1  taken decision from the branch-evaluation unit.
- ExPC  in  XLEN  PC of the EX instruction.
- ExImm  in  XLEN  sign-extended immediate.
- ExRs1  in  XLEN  forwarded rs1 value.
- ExPredTaken  in  1  fetch predicted taken.
- ExPredTarget  in  XLEN  fetch predicted target.
- RedirectReady  in  1  fetch accepts redirect.
- RedirectValid  out  1  redirect request.
- RedirectPC  out  XLEN  correct next PC.
- FlushIF  out  1  squash IF/ID register.
- FlushID  out  1  squash ID/EX register.
- StallEX  out  1  hold EX stage.
- UpdValid  out  1  predictor update pulse.
- UpdPC  out  XLEN  PC of resolved instruction.
- UpdTaken  out  1  resolved direction.
- UpdTarget  out  XLEN  resolved target.
- TrapValid  out  1  instruction-address-misaligned trap pulse.
- TrapPC  out  XLEN  faulting instruction PC.
- TrapTval  out  XLEN  misaligned target.

Behaviour:
- All outputs are registered. Async reset forces state IDLE and every output to 0 (all PC/target buses 0).
- Control-flow instruction (CF): ExValid=1 and (ExBrOp[4]=1 or ExBrOp[4:3]!=00).
- Target:
  - JALR: (ExRs1+ExImm) & ~1.
  - Otherwise: ExPC+ExImm.
  - All arithmetic is modulo 2^XLEN (wraps, no overflow flag).
- Actual next PC (ActNext): Target if ExTaken else ExPC+4.
- Misaligned: ExTaken=1 and Target[1:0]!=00. No C extension.
- Mispredict: ExTaken!=ExPredTaken, or (ExTaken=1 and Target!=ExPredTarget).
- States: IDLE, REDIRECT, TRAP.
- IDLE, CF evaluated in cycle N:
  - Every CF: UpdValid=1 in N+1 for exactly one cycle, with UpdPC=ExPC, UpdTaken=ExTaken, UpdTarget=Target. This includes misaligned CFs.
  - If misaligned (priority over mispredict): go to TRAP. TrapValid=1 for one cycle at N+1, TrapPC=ExPC, TrapTval=Target, FlushIF=FlushID=1 in N+1. No redirect.
  - Else if mispredict: go to REDIRECT. At N+1, RedirectValid=1, RedirectPC=ActNext, FlushIF=FlushID=StallEX=1.
  - Else stay in IDLE.
- Non-CF or ExValid=0 in IDLE: no action.
- REDIRECT:
  - RedirectValid, RedirectPC, FlushIF, FlushID and StallEX are held stable until RedirectValid&&RedirectReady is sampled.
  - That edge returns to IDLE; all five outputs are 0 in the following cycle.
  - ExValid/ExTaken are ignored while in REDIRECT.
  - Minimum redirect latency: 1 cycle from detection to RedirectValid, 2 cycles to IDLE if RedirectReady is already high.
- TRAP: always returns to IDLE after one cycle.
- Single-cycle pulses (UpdValid, TrapValid) never last longer than one cycle.
- ExValid=1 in the same cycle as the return to IDLE is evaluated normally (back-to-back resolution allowed).
- rst_n low mid-REDIRECT: the redirect is aborted immediately (async), with no acceptance required.

Optional Feature:
- Macro: BRANCH_REDIRECT_PERF_EN.
- When defined, adds three outputs, each PERF_W wide and cleared by reset:
  - PerfBranches: incremented per CF evaluated in IDLE.
  - PerfMispred: incremented per redirect entry.
  - PerfStallCyc: incremented per cycle spent in REDIRECT.
- All three counters wrap at 2^PERF_W.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- BEQ: ExPC=0x100, ExImm=0x20, ExTaken=1, ExPredTaken=0, RedirectReady=1 -> next cycle RedirectValid=1, RedirectPC=0x120, FlushIF=FlushID=StallEX=1, UpdValid=1; the following cycle all are 0.
- BNE: ExPC=0x200, ExTaken=0, ExPredTaken=0 -> UpdValid pulse with UpdTaken=0, UpdTarget=0x200+ExImm; no redirect, no flush.
- JALR: ExRs1=0x1001, ExImm=0x10, ExPredTarget=0x1000, ExPredTaken=1, RedirectReady low 3 cycles then high -> RedirectPC=0x1010 held stable 4 cycles, then return to IDLE.
- JAL: ExPC=0x300, ExImm=0x6, ExTaken=1 -> TrapValid pulse, TrapPC=0x300, TrapTval=0x306, flushes for one cycle, RedirectValid stays 0.
- Reset in REDIRECT: rst_n driven low while RedirectValid=1 and RedirectReady=0 -> all outputs 0 immediately; after release, state IDLE and a new BEQ mispredict redirects normally.
- Non-CF (ExBrOp=00000, ExValid=1, ExTaken=1) -> no UpdValid, no redirect; with BRANCH_REDIRECT_PERF_EN defined, PerfBranches is unchanged.
